// File: rtl/cpu_core_p_if.sv
// Instruction-fetch port of cpu_core_p: the core drives the address, the
// memory side returns the instruction word with a valid qualifier.
interface cpu_core_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int INSTR_W = 6 + 2 * (DATA_W + 1) + ADDR_W;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [ADDR_W-1:0]  instr_addr;

  modport master (output instr_addr, input instr, input instr_valid);
  modport slave  (input instr_addr, output instr, output instr_valid);
endinterface

// File: rtl/cpu_core_p.sv
// cpu_core_p: single-issue register core with fetch handshake, HALT/FAULT states
// and an optional hardware call/return stack built when CPU_CALL_STACK_EN is defined.
module cpu_core_p #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int REG_COUNT   = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  cpu_core_p_if.master      fetch,
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        gpi,
  output logic [DATA_W-1:0] dout,
  output logic [7:0]        flags,
  output logic              halted,
  output logic              fault
);
  localparam int REG_AW = $clog2(REG_COUNT);
  localparam int MSB    = DATA_W - 1;

  localparam logic [2:0] GRP_ALU = 3'd0;
  localparam logic [2:0] GRP_CTL = 3'd1;
  localparam logic [2:0] GRP_BTS = 3'd2;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_MOV
  } alu_op_e;

  typedef enum logic [2:0] {
    CTL_JMP, CTL_BEQ, CTL_BNE, CTL_BLT, CTL_BLTU, CTL_CALL, CTL_RET, CTL_HALT
  } ctl_op_e;

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_e;

  typedef struct packed {
    logic [2:0]        group;
    logic [2:0]        cmd;
    logic              t1;
    logic [DATA_W-1:0] a1;
    logic              t2;
    logic [DATA_W-1:0] a2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  if (DATA_W < 8 || DATA_W > 16) begin : g_chk_data_w
    $error("cpu_core_p: DATA_W must be within 8..16");
  end
  if (REG_COUNT < 4 || REG_COUNT > 32 || (REG_COUNT & (REG_COUNT - 1)) != 0) begin : g_chk_regs
    $error("cpu_core_p: REG_COUNT must be a power of two within 4..32");
  end
  if (STACK_DEPTH < 2) begin : g_chk_stack
    $error("cpu_core_p: STACK_DEPTH must be at least 2");
  end

  instr_t             ins;
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ip_q, ip_d, ip_inc;
  logic               exec;
  logic [DATA_W-1:0]  regs    [REG_COUNT];
  logic [DATA_W-1:0]  rf_view [REG_COUNT];
  logic [DATA_W-1:0]  flags_ext;
  logic [3:0]         flags_q;
  logic [REG_AW-1:0]  idx_a, idx_b;
  logic [DATA_W-1:0]  op_a, op_b;
  logic [DATA_W:0]    sum_ext, diff_ext;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_c, alu_v;
  logic               rf_we, flags_we;
`ifdef CPU_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]    sp_q;
  logic [IDX_W-1:0]   top_idx;
  logic               stack_full, stack_empty, push, pop;
  logic [ADDR_W-1:0]  stack_top;
`endif

  assign ins    = fetch.instr;
  assign exec   = enable && fetch.instr_valid && (state_q == ST_RUN);
  assign ip_inc = ip_q + ADDR_W'(1);

  assign fetch.instr_addr = ip_q;
  assign dout             = regs[1];
  assign flags            = {gpi, flags_q};
  assign halted           = (state_q != ST_RUN);

  // R0 and R2 are read-only views of din and the flag byte.
  always_comb begin
    flags_ext      = '0;
    flags_ext[7:0] = flags;
    for (int i = 0; i < REG_COUNT; i++) rf_view[i] = regs[i];
    rf_view[0] = din;
    rf_view[2] = flags_ext;
  end

  assign idx_a = ins.a1[REG_AW-1:0];
  assign idx_b = ins.a2[REG_AW-1:0];
  assign op_a  = ins.t1 ? rf_view[idx_a] : ins.a1;
  assign op_b  = ins.t2 ? rf_view[idx_b] : ins.a2;

  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res = op_a;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (alu_op_e'(ins.cmd))
      ALU_ADD: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      ALU_SUB: begin
        alu_res = diff_ext[MSB:0];
        alu_c   = diff_ext[DATA_W];
        alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SHL: begin
        alu_res = {op_a[MSB-1:0], 1'b0};
        alu_c   = op_a[MSB];
      end
      ALU_SHR: begin
        alu_res = {1'b0, op_a[MSB:1]};
        alu_c   = op_a[0];
      end
      ALU_MOV: alu_res = op_a;
    endcase
  end

`ifdef CPU_CALL_STACK_EN
  assign top_idx     = IDX_W'(sp_q - SP_W'(1));
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign stack_top   = stack_mem[top_idx];
  assign fault       = (state_q == ST_FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     sp_q <= '0;
    else if (push) sp_q <= sp_q + SP_W'(1);
    else if (pop)  sp_q <= sp_q - SP_W'(1);
  end

  // NOTE: stack storage is not reset; the pointer alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack_mem[IDX_W'(sp_q)] <= ip_inc;
  end
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ip_d     = ip_q;
    rf_we    = 1'b0;
    flags_we = 1'b0;
`ifdef CPU_CALL_STACK_EN
    push     = 1'b0;
    pop      = 1'b0;
`endif
    if (exec) begin
      ip_d = ip_inc;
      unique case (ins.group)
        GRP_ALU: begin
          flags_we = 1'b1;
          rf_we    = ins.t2;
        end
        GRP_CTL: begin
          unique case (ctl_op_e'(ins.cmd))
            CTL_JMP:  ip_d = ins.addr;
            CTL_BEQ:  if (op_a == op_b) ip_d = ins.addr;
            CTL_BNE:  if (op_a != op_b) ip_d = ins.addr;
            CTL_BLT:  if ($signed(op_a) < $signed(op_b)) ip_d = ins.addr;
            CTL_BLTU: if (op_a < op_b) ip_d = ins.addr;
            CTL_CALL: begin
`ifdef CPU_CALL_STACK_EN
              if (stack_full) begin
                state_d = ST_FAULT;
                ip_d    = ip_q;
              end else begin
                push = 1'b1;
                ip_d = ins.addr;
              end
`endif
            end
            CTL_RET: begin
`ifdef CPU_CALL_STACK_EN
              if (stack_empty) begin
                state_d = ST_FAULT;
                ip_d    = ip_q;
              end else begin
                pop  = 1'b1;
                ip_d = stack_top;
              end
`endif
            end
            CTL_HALT: begin
              state_d = ST_HALT;
              ip_d    = ip_q;
            end
          endcase
        end
        GRP_BTS: if (flags[ins.cmd]) ip_d = ins.addr;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      ip_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      if (flags_we) flags_q <= {alu_res[MSB], alu_v, alu_c, alu_res == '0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (rf_we && idx_b != REG_AW'(0) && idx_b != REG_AW'(2)) begin
      regs[idx_b] <= alu_res;
    end
  end
endmodule

// File: tb/tb_cpu_core_p.sv
// Scoreboard bench for cpu_core_p: a driver steps an instruction-level reference
// model and queues expectations; a monitor compares them after each clock edge.
module tb_cpu_core_p;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int MASK  = (1 << DW) - 1;
  localparam int AMASK = (1 << AW) - 1;
  localparam int SMAX  = (1 << (DW - 1)) - 1;
  localparam int SMIN  = -(1 << (DW - 1));
  localparam int DEPTH = 8;
  localparam int S_RUN = 0, S_HALT = 1, S_FAULT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] din = '0;
  logic [3:0]    gpi = '0;
  logic [DW-1:0] dout;
  logic [7:0]    flags;
  logic          halted, fault;

  cpu_core_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  cpu_core_p #(.DATA_W(DW), .ADDR_W(AW), .REG_COUNT(16), .STACK_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .fetch  (bus),
    .din    (din),
    .gpi    (gpi),
    .dout   (dout),
    .flags  (flags),
    .halted (halted),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  typedef struct { int ip, dout, flags, halted, fault; } exp_t;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] prog [256];
  int m_ip, m_state, m_z, m_c, m_v, m_n;
  int m_r [16];
  int m_stack[$];

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] mk(int g, int c, int t1, int a1, int t2, int a2, int ad);
    logic [31:0] w;
    w = {3'(g), 3'(c), 1'(t1), 8'(a1), 1'(t2), 8'(a2), 8'(ad)};
    return w;
  endfunction

  function automatic int flags_lo();
    return m_z | (m_c << 1) | (m_v << 2) | (m_n << 3);
  endfunction

  function automatic int sx(int v);
    return (v > SMAX) ? v - (1 << DW) : v;
  endfunction

  function automatic int rd(int idx);
    int i = idx % 16;
    if (i == 0) return int'(din);
    if (i == 2) return (int'(gpi) << 4) | flags_lo();
    return m_r[i];
  endfunction

  task automatic model_reset();
    m_ip = 0; m_state = S_RUN;
    m_z = 0; m_c = 0; m_v = 0; m_n = 0;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    m_stack.delete();
  endtask

  // One instruction, computed from the architectural rules with integer arithmetic.
  task automatic model_exec(input logic [31:0] w);
    int g, c, t1, a1, t2, a2, ad, a, b, sa, sb, res, nxt, taken, allf;
    g = int'(w[31:29]); c = int'(w[28:26]); t1 = int'(w[25]); a1 = int'(w[24:17]);
    t2 = int'(w[16]); a2 = int'(w[15:8]); ad = int'(w[7:0]);
    a = t1 ? rd(a1) : a1;
    b = t2 ? rd(a2) : a2;
    sa = sx(a); sb = sx(b);
    nxt = (m_ip + 1) & AMASK;
    taken = 0;
    case (g)
      0: begin
        m_c = 0; m_v = 0; res = a;
        case (c)
          0: begin res = a + b; m_c = int'(res > MASK); m_v = int'(sa + sb > SMAX || sa + sb < SMIN); end
          1: begin res = a - b; m_c = int'(a < b);      m_v = int'(sa - sb > SMAX || sa - sb < SMIN); end
          2: res = a & b;
          3: res = a | b;
          4: res = a ^ b;
          5: begin res = a * 2; m_c = int'(a > SMAX); end
          6: begin res = a / 2; m_c = a % 2; end
          default: res = a;
        endcase
        res = res & MASK;
        m_z = int'(res == 0);
        m_n = int'(res > SMAX);
        if (t2 != 0 && (a2 % 16) != 0 && (a2 % 16) != 2) m_r[a2 % 16] = res;
      end
      1: begin
        case (c)
          0: taken = 1;
          1: taken = int'(a == b);
          2: taken = int'(a != b);
          3: taken = int'(sa < sb);
          4: taken = int'(a < b);
`ifdef CPU_CALL_STACK_EN
          5: if (m_stack.size() == DEPTH) begin m_state = S_FAULT; nxt = m_ip; end
             else begin m_stack.push_back(nxt); nxt = ad; end
          6: if (m_stack.size() == 0) begin m_state = S_FAULT; nxt = m_ip; end
             else nxt = m_stack.pop_back();
`endif
          7: begin m_state = S_HALT; nxt = m_ip; end
          default: ;
        endcase
      end
      2: begin
        allf  = (int'(gpi) << 4) | flags_lo();
        taken = (allf >> c) & 1;
      end
      default: ;
    endcase
    if (taken != 0) nxt = ad;
    m_ip = nxt;
  endtask

  // Each driven cycle queues one expectation; the run ends quiescent at posedge+3.
  task automatic run(input int n, input int valid_pct, input int en_pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.instr_valid = ($urandom_range(0, 99) < valid_pct);
      enable          = ($urandom_range(0, 99) < en_pct);
      din             = DW'($urandom);
      gpi             = 4'($urandom);
      bus.instr       = prog[bus.instr_addr];
      if (enable && bus.instr_valid && m_state == S_RUN) model_exec(prog[m_ip]);
      exp_q.push_back('{m_ip, m_r[1], (int'(gpi) << 4) | flags_lo(),
                        int'(m_state != S_RUN), int'(m_state == S_FAULT)});
    end
    @(posedge clk); #3;
    bus.instr_valid = 1'b0;
    enable          = 1'b0;
  endtask

  // Reset is raised between clock edges and checked before any edge arrives.
  task automatic reset_dut();
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    #1;
    check("rst_addr",   bus.instr_addr, 0);
    check("rst_dout",   dout, 0);
    check("rst_flags",  flags[3:0], 0);
    check("rst_halted", halted, 0);
    check("rst_fault",  fault, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) prog[i] = mk(3, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_random();
    for (int i = 0; i < 256; i++) begin
      int g, c;
      g = $urandom_range(0, 4);
      c = $urandom_range(0, 7);
      if (g == 1 && c == 7 && $urandom_range(0, 31) != 0) c = 0;
      prog[i] = mk(g, c, $urandom_range(0, 1), $urandom_range(0, 255),
                   $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255));
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ip",     bus.instr_addr, e.ip);
        check("dout",   dout, e.dout);
        check("flags",  flags, e.flags);
        check("halted", halted, e.halted);
        check("fault",  fault, e.fault);
      end
    end
  end

  initial begin : driver
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    model_reset();

    // Write-back, flags, signed vs unsigned branch, stall hold, HALT.
    reset_dut();
    fill_nop();
    prog[0]    = mk(0, 7, 0, 8'hFF, 1, 1, 0);
    prog[1]    = mk(0, 0, 0, 1, 1, 1, 0);
    prog[2]    = mk(0, 7, 0, 8'h80, 1, 3, 0);
    prog[3]    = mk(1, 3, 1, 3, 0, 1, 8'h20);
    prog[8'h20] = mk(1, 4, 1, 3, 0, 1, 8'h40);
    prog[8'h21] = mk(1, 0, 0, 0, 0, 0, 5);
    prog[5]    = mk(1, 7, 0, 0, 0, 0, 0);
    run(2, 100, 100);
    check("add_dout",  dout, 0);
    check("add_flags", flags[3:0], 4'b0011);
    run(3, 0, 100);
    check("stall_addr", bus.instr_addr, 2);
    check("stall_dout", dout, 0);
    run(12, 100, 100);
    check("halt_addr",   bus.instr_addr, 5);
    check("halt_halted", halted, 1);
    check("halt_fault",  fault, 0);

    // Address wrap across a stall.
    reset_dut();
    fill_nop();
    prog[0] = mk(1, 0, 0, 0, 0, 0, 8'hFE);
    run(2, 100, 100);
    check("wrap_pre", bus.instr_addr, 8'hFF);
    run(3, 0, 100);
    check("wrap_hold", bus.instr_addr, 8'hFF);
    run(1, 100, 100);
    check("wrap_post", bus.instr_addr, 0);

    // Eight nested CALLs, eight RETs, then a chain that overflows the stack.
    reset_dut();
    fill_nop();
    for (int i = 0; i < 8; i++) prog[16 * i] = mk(1, 5, 0, 0, 0, 0, 16 * (i + 1));
    prog[8'h80] = mk(1, 6, 0, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++) prog[16 * i + 1] = mk(1, 6, 0, 0, 0, 0, 0);
    prog[1] = mk(1, 5, 0, 0, 0, 0, 8'h90);
    for (int k = 0; k < 9; k++) prog[8'h90 + 4 * k] = mk(1, 5, 0, 0, 0, 0, 8'h90 + 4 * (k + 1));
    run(1, 100, 100);
`ifdef CPU_CALL_STACK_EN
    check("call_target", bus.instr_addr, 8'h10);
    run(29, 100, 100);
    check("ovf_addr",   bus.instr_addr, 8'hAC);
    check("ovf_fault",  fault, 1);
    check("ovf_halted", halted, 1);
`else
    check("call_nop", bus.instr_addr, 1);
    run(29, 100, 100);
    check("nostack_fault", fault, 0);
`endif

    // Randomised programs with a reset landing in the middle.
    reset_dut();
    load_random();
    run(400, 80, 90);
    reset_dut();
    load_random();
    run(400, 80, 90);

    #20;
    check("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
